hdmi_link_sequencer: RTL and testbench
======================================

HDMI_LINK_SEQUENCER -- requirements
Module: hdmi_link_sequencer

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- RST_CYC, 16, clk25 cycles tx_pll_reset is held.
- FLUSH_CYC, 8, clk25 cycles fifo_rst is held.
- LOCK_TIMEOUT, 65535, max clk25 cycles in WAIT_TX_LOCK before retry.
- DEBOUNCE_CYC, 250000, stable cycles before a select change is accepted (10 ms).

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk25  in  1  system clock.
- rstin  in  1  reset, asynchronous, active-high.
- rx_plllckd  in  1  RX PLL lock, async.
- rx_psalgnerr  in  1  RX phase-align error, async.
- tx_bufpll_lock  in  1  TX BUFPLL lock, async.
- fifo_full  in  1  pixel FIFO full, async.
- fifo_empty  in  1  pixel FIFO empty, async.
- fifo_half  in  1  pixel FIFO at or above half, async.
- sel_sw  in  2  raw source-select switches.
- tx_pll_reset  out  1  TX PLL reset.
- fifo_rst  out  1  pixel FIFO reset.
- fifo_wr_en  out  1  FIFO write gate.
- fifo_rd_en  out  1  FIFO read gate.
- clk_sel  out  2  BUFGMUX select, debounced.
- link_up  out  1  high only in RUN.
- state  out  3  state code.
- err_cnt  out  8  saturating error count.

Function
REQ-003 Every async input SHALL pass through a 2-flop synchronizer; all decisions SHALL use synchronized values, giving 2-cycle input latency.
REQ-004 States and codes SHALL be: WAIT_RX=0, TX_RST=1, WAIT_TX=2, FLUSH=3, FILL=4, RUN=5, RESEL=6.
REQ-005 WAIT_RX: tx_pll_reset=1, fifo_rst=1, gates 0; go to TX_RST when rx_plllckd=1.
REQ-006 TX_RST: tx_pll_reset=1 for exactly RST_CYC cycles, then go to WAIT_TX.
REQ-007 WAIT_TX: tx_pll_reset=0; go to FLUSH on tx_bufpll_lock=1; after LOCK_TIMEOUT cycles without lock, go to TX_RST and increment err_cnt.
REQ-008 FLUSH: fifo_rst=1 and gates 0 for exactly FLUSH_CYC cycles, then go to FILL.
REQ-009 FILL: fifo_wr_en=1, fifo_rd_en=0; go to RUN on fifo_half=1.
REQ-010 RUN: fifo_wr_en=1, fifo_rd_en=1, link_up=1.
REQ-011 RUN exits SHALL be checked in this priority, highest first:
- rx_plllckd=0 -> WAIT_RX.
- debounced select change -> RESEL.
- tx_bufpll_lock=0 -> TX_RST.
- fifo_full=1 or fifo_empty=1 -> FLUSH.
REQ-012 A loss of rx_plllckd in any state other than WAIT_RX SHALL force WAIT_RX on the next cycle.
REQ-013 err_cnt SHALL increment by 1 on each of the following, saturating at 255:
- every RUN exit except RESEL;
- every WAIT_TX timeout;
- each rising edge of synchronized rx_psalgnerr.
Simultaneous events in one cycle SHALL add exactly 1.
REQ-014 Debounce: sel_sw SHALL be stable for DEBOUNCE_CYC consecutive cycles before it becomes a new sel_stable; a change during counting SHALL restart the count.
REQ-015 clk_sel SHALL change only in RESEL, on the state's first cycle, while tx_pll_reset=1 and fifo_rst=1; RESEL then goes to TX_RST after 1 cycle.
REQ-016 A select change accepted outside RUN SHALL update clk_sel immediately only in WAIT_RX or TX_RST; otherwise it is held pending until RUN or WAIT_RX.
REQ-017 All outputs SHALL be registered.

Reset
REQ-018 Asserting rstin SHALL force, asynchronously:
- state=WAIT_RX;
- tx_pll_reset=1, fifo_rst=1;
- fifo_wr_en=0, fifo_rd_en=0, link_up=0;
- clk_sel=2'b00, err_cnt=0;
- all counters and synchronizers to 0.
REQ-019 Assertion of rstin in any state, including mid-FLUSH or mid-debounce, SHALL abandon that operation with no residual effect.

Structure
REQ-020 State encodings and parameter defaults SHALL live in shared package hdmi_pkg.
REQ-021 The synchronizer-plus-debouncer SHALL be sub-module sel_debounce; everything else is flat.

Verification
REQ-022 Bench SHALL cover, with RST_CYC=4, FLUSH_CYC=3, LOCK_TIMEOUT=20, DEBOUNCE_CYC=5:
- Bring-up: rx lock at cycle 10, tx lock 5 cycles after WAIT_TX entry, fifo_half 6 cycles into FILL -> tx_pll_reset high exactly 4 cycles, fifo_rst high exactly 3 cycles in FLUSH, link_up=1, err_cnt=0.
- tx lock never asserted -> WAIT_TX->TX_RST every 20 cycles, err_cnt=3 after 3 retries.
- fifo_empty pulse in RUN -> FLUSH, err_cnt +1, relocks to RUN.
- sel_sw 00->01 stable 5 cycles in RUN -> RESEL, clk_sel=01 with tx_pll_reset=1, err_cnt unchanged; a glitch of 3 cycles -> no change.
- rx lock drop coinciding with fifo_full in RUN -> WAIT_RX, err_cnt +1 only.
- rstin mid-FLUSH -> all outputs at reset values the same cycle; 300 psalgnerr pulses -> err_cnt=255.

Source files
------------

// File: rtl/hdmi_pkg.sv
// rtl/hdmi_pkg.sv - shared state codes, parameter defaults and per-state output drive
package hdmi_pkg;

   localparam int RST_CYC_DEF      = 16;
   localparam int FLUSH_CYC_DEF    = 8;
   localparam int LOCK_TIMEOUT_DEF = 65535;
   localparam int DEBOUNCE_CYC_DEF = 250000;

   typedef enum logic [2:0] {
      WAIT_RX = 3'd0,
      TX_RST  = 3'd1,
      WAIT_TX = 3'd2,
      FLUSH   = 3'd3,
      FILL    = 3'd4,
      RUN     = 3'd5,
      RESEL   = 3'd6
   } state_t;

   typedef struct packed {
      logic tx_pll_reset;
      logic fifo_rst;
      logic fifo_wr_en;
      logic fifo_rd_en;
      logic link_up;
   } drive_t;

   // Output levels a state presents for its whole residency.
   function automatic drive_t state_drive(input state_t s);
      drive_t d;
      case (s)
         WAIT_RX, TX_RST, RESEL: d = drive_t'(5'b11000);
         FLUSH:                  d = drive_t'(5'b01000);
         FILL:                   d = drive_t'(5'b00100);
         RUN:                    d = drive_t'(5'b00111);
         default:                d = drive_t'(5'b00000);
      endcase
      return d;
   endfunction

endpackage

// File: rtl/sel_debounce.sv
// rtl/sel_debounce.sv - synchronizes the source-select switches and accepts a new value
// only after it has been held for DEBOUNCE_CYC consecutive cycles.
module sel_debounce
   import hdmi_pkg::*;
#(
   parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
) (
   input  logic       clk25,
   input  logic       rstin,
   input  logic [1:0] sel_sw,
   output logic [1:0] sel_stable
);

   localparam int              CNT_W    = $clog2(DEBOUNCE_CYC + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [1:0]       sync1;
   logic [1:0]       sync2;
   logic [1:0]       cand;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk25 or posedge rstin) begin
      if (rstin) begin
         sync1      <= 2'b00;
         sync2      <= 2'b00;
         cand       <= 2'b00;
         cnt        <= '0;
         sel_stable <= 2'b00;
      end else begin
         sync1 <= sel_sw;
         sync2 <= sync1;
         // cand tracks the value being timed; any new value restarts at one seen cycle.
         if (sync2 == sel_stable) begin
            cand <= sel_stable;
            cnt  <= '0;
         end else if (sync2 != cand) begin
            cand <= sync2;
            cnt  <= CNT_ONE;
         end else if (cnt >= CNT_LAST) begin
            sel_stable <= cand;
            cnt        <= '0;
         end else begin
            cnt <= cnt + CNT_ONE;
         end
      end
   end

endmodule

// File: rtl/hdmi_link_sequencer.sv
// rtl/hdmi_link_sequencer.sv - brings up the HDMI TX PLL and pixel FIFO behind the RX lock,
// supervises the running link and counts link faults.
module hdmi_link_sequencer
   import hdmi_pkg::*;
#(
   parameter int RST_CYC      = RST_CYC_DEF,
   parameter int FLUSH_CYC    = FLUSH_CYC_DEF,
   parameter int LOCK_TIMEOUT = LOCK_TIMEOUT_DEF,
   parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
) (
   input  logic       clk25,
   input  logic       rstin,
   input  logic       rx_plllckd,
   input  logic       rx_psalgnerr,
   input  logic       tx_bufpll_lock,
   input  logic       fifo_full,
   input  logic       fifo_empty,
   input  logic       fifo_half,
   input  logic [1:0] sel_sw,
   output logic       tx_pll_reset,
   output logic       fifo_rst,
   output logic       fifo_wr_en,
   output logic       fifo_rd_en,
   output logic [1:0] clk_sel,
   output logic       link_up,
   output logic [2:0] state,
   output logic [7:0] err_cnt
);

   localparam logic [31:0] RST_LAST   = 32'(RST_CYC - 1);
   localparam logic [31:0] FLUSH_LAST = 32'(FLUSH_CYC - 1);
   localparam logic [31:0] LOCK_LAST  = 32'(LOCK_TIMEOUT - 1);

   logic [5:0]  meta;
   logic [5:0]  sync;
   logic        psal_d;
   logic [1:0]  sel_stable;
   state_t      cur;
   state_t      nxt;
   drive_t      drv;
   logic [31:0] cyc_cnt;
   logic        fault;

   logic rx_lock, psal, tx_lock, full_s, empty_s, half_s, psal_rise, sel_pend;

   assign {rx_lock, psal, tx_lock, full_s, empty_s, half_s} = sync;
   assign psal_rise = psal & ~psal_d;
   assign sel_pend  = (sel_stable != clk_sel);

   sel_debounce #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC)
   ) u_sel_debounce (
      .clk25      (clk25),
      .rstin      (rstin),
      .sel_sw     (sel_sw),
      .sel_stable (sel_stable)
   );

   // RX lock loss overrides everything; within RUN the exits follow a fixed priority.
   always_comb begin
      nxt   = cur;
      fault = 1'b0;
      if (cur != WAIT_RX && !rx_lock) begin
         nxt   = WAIT_RX;
         fault = (cur == RUN);
      end else begin
         case (cur)
            WAIT_RX: if (rx_lock) nxt = TX_RST;
            TX_RST:  if (cyc_cnt == RST_LAST) nxt = WAIT_TX;
            WAIT_TX: begin
               if (tx_lock) begin
                  nxt = FLUSH;
               end else if (cyc_cnt == LOCK_LAST) begin
                  nxt   = TX_RST;
                  fault = 1'b1;
               end
            end
            FLUSH:   if (cyc_cnt == FLUSH_LAST) nxt = FILL;
            FILL:    if (half_s) nxt = RUN;
            RUN: begin
               if (sel_pend) begin
                  nxt = RESEL;
               end else if (!tx_lock) begin
                  nxt   = TX_RST;
                  fault = 1'b1;
               end else if (full_s || empty_s) begin
                  nxt   = FLUSH;
                  fault = 1'b1;
               end
            end
            RESEL:   nxt = TX_RST;
            default: nxt = WAIT_RX;
         endcase
      end
   end

   always_ff @(posedge clk25 or posedge rstin) begin
      if (rstin) begin
         meta    <= '0;
         sync    <= '0;
         psal_d  <= 1'b0;
         cur     <= WAIT_RX;
         drv     <= state_drive(WAIT_RX);
         cyc_cnt <= '0;
         err_cnt <= 8'd0;
         clk_sel <= 2'b00;
      end else begin
         meta    <= {rx_plllckd, rx_psalgnerr, tx_bufpll_lock, fifo_full, fifo_empty, fifo_half};
         sync    <= meta;
         psal_d  <= psal;
         cur     <= nxt;
         drv     <= state_drive(nxt);
         cyc_cnt <= (nxt != cur) ? 32'd0 : cyc_cnt + 32'd1;
         // Coincident fault and phase-align events still count once.
         if ((fault || psal_rise) && err_cnt != 8'hFF)
            err_cnt <= err_cnt + 8'd1;
         // The mux only moves while both the TX PLL and the FIFO are held in reset.
         if (sel_pend && (nxt == RESEL ||
                          (nxt == cur && (cur == WAIT_RX || cur == TX_RST))))
            clk_sel <= sel_stable;
      end
   end

   assign state        = cur;
   assign tx_pll_reset = drv.tx_pll_reset;
   assign fifo_rst     = drv.fifo_rst;
   assign fifo_wr_en   = drv.fifo_wr_en;
   assign fifo_rd_en   = drv.fifo_rd_en;
   assign link_up      = drv.link_up;

endmodule

// File: tb/tb_hdmi_link_sequencer.sv
// tb/tb_hdmi_link_sequencer.sv - directed self-checking bench for hdmi_link_sequencer
module tb_hdmi_link_sequencer;

   localparam logic [2:0] S_WAIT_RX = 3'd0;
   localparam logic [2:0] S_TX_RST  = 3'd1;
   localparam logic [2:0] S_WAIT_TX = 3'd2;
   localparam logic [2:0] S_FLUSH   = 3'd3;
   localparam logic [2:0] S_FILL    = 3'd4;
   localparam logic [2:0] S_RUN     = 3'd5;
   localparam logic [2:0] S_RESEL   = 3'd6;

   logic       clk25 = 1'b0;
   logic       rstin = 1'b1;
   logic       rx_plllckd = 1'b0;
   logic       rx_psalgnerr = 1'b0;
   logic       tx_bufpll_lock = 1'b0;
   logic       fifo_full = 1'b0;
   logic       fifo_empty = 1'b0;
   logic       fifo_half = 1'b0;
   logic [1:0] sel_sw = 2'b00;
   logic       tx_pll_reset, fifo_rst, fifo_wr_en, fifo_rd_en, link_up;
   logic [1:0] clk_sel;
   logic [2:0] state;
   logic [7:0] err_cnt;

   int checks = 0;
   int errors = 0;

   always #5 clk25 = ~clk25;

   hdmi_link_sequencer #(
      .RST_CYC      (4),
      .FLUSH_CYC    (3),
      .LOCK_TIMEOUT (20),
      .DEBOUNCE_CYC (5)
   ) dut (
      .clk25          (clk25),
      .rstin          (rstin),
      .rx_plllckd     (rx_plllckd),
      .rx_psalgnerr   (rx_psalgnerr),
      .tx_bufpll_lock (tx_bufpll_lock),
      .fifo_full      (fifo_full),
      .fifo_empty     (fifo_empty),
      .fifo_half      (fifo_half),
      .sel_sw         (sel_sw),
      .tx_pll_reset   (tx_pll_reset),
      .fifo_rst       (fifo_rst),
      .fifo_wr_en     (fifo_wr_en),
      .fifo_rd_en     (fifo_rd_en),
      .clk_sel        (clk_sel),
      .link_up        (link_up),
      .state          (state),
      .err_cnt        (err_cnt)
   );

   task automatic tick();
      @(posedge clk25);
      #1;
   endtask

   task automatic wait_state(input logic [2:0] s, input int budget, output bit ok);
      int i;
      i  = 0;
      ok = (state === s);
      while (!ok && i < budget) begin
         tick();
         i++;
         ok = (state === s);
      end
   endtask

   task automatic do_reset();
      rstin          = 1'b1;
      rx_plllckd     = 1'b0;
      rx_psalgnerr   = 1'b0;
      tx_bufpll_lock = 1'b0;
      fifo_full      = 1'b0;
      fifo_empty     = 1'b0;
      fifo_half      = 1'b0;
      sel_sw         = 2'b00;
      repeat (2) tick();
      rstin = 1'b0;
      tick();
   endtask

   task automatic bring_up();
      bit ok;
      rx_plllckd     = 1'b1;
      tx_bufpll_lock = 1'b1;
      fifo_half      = 1'b1;
      wait_state(S_RUN, 100, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL bring_up_run: state %0d, required %0d", state, S_RUN);
      end
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (state !== S_WAIT_RX) begin
         errors++; $display("FAIL reset_state: got %0d required %0d", state, S_WAIT_RX);
      end
      checks++;
      if ({tx_pll_reset, fifo_rst} !== 2'b11) begin
         errors++; $display("FAIL reset_resets: got %b required 11", {tx_pll_reset, fifo_rst});
      end
      checks++;
      if ({fifo_wr_en, fifo_rd_en, link_up} !== 3'b000) begin
         errors++; $display("FAIL reset_gates: got %b required 000", {fifo_wr_en, fifo_rd_en, link_up});
      end
      checks++;
      if (clk_sel !== 2'b00 || err_cnt !== 8'd0) begin
         errors++; $display("FAIL reset_sel_err: got clk_sel %b err %0d required 00 / 0", clk_sel, err_cnt);
      end
   endtask

   task automatic test_bring_up();
      bit ok;
      int n_hi, n_gate, guard;
      do_reset();
      repeat (10) tick();
      rx_plllckd = 1'b1;
      wait_state(S_TX_RST, 20, ok);
      n_hi = 0; guard = 0;
      while (state === S_TX_RST && guard < 50) begin
         if (tx_pll_reset) n_hi++;
         tick(); guard++;
      end
      checks++;
      if (!ok || n_hi != 4) begin
         errors++; $display("FAIL bringup_tx_rst_len: got %0d required 4", n_hi);
      end
      checks++;
      if (state !== S_WAIT_TX || tx_pll_reset !== 1'b0) begin
         errors++; $display("FAIL bringup_wait_tx: got state %0d pll_rst %b required 2 / 0", state, tx_pll_reset);
      end
      repeat (5) tick();
      tx_bufpll_lock = 1'b1;
      wait_state(S_FLUSH, 20, ok);
      n_hi = 0; n_gate = 0; guard = 0;
      while (state === S_FLUSH && guard < 50) begin
         if (fifo_rst) n_hi++;
         if (fifo_wr_en || fifo_rd_en) n_gate++;
         tick(); guard++;
      end
      checks++;
      if (!ok || n_hi != 3 || n_gate != 0) begin
         errors++; $display("FAIL bringup_flush: got rst %0d gates %0d required 3 / 0", n_hi, n_gate);
      end
      checks++;
      if (state !== S_FILL || {fifo_wr_en, fifo_rd_en} !== 2'b10) begin
         errors++; $display("FAIL bringup_fill: got state %0d gates %b required 4 / 10", state, {fifo_wr_en, fifo_rd_en});
      end
      repeat (6) tick();
      fifo_half = 1'b1;
      wait_state(S_RUN, 20, ok);
      checks++;
      if (!ok || link_up !== 1'b1 || {fifo_wr_en, fifo_rd_en} !== 2'b11 || err_cnt !== 8'd0) begin
         errors++; $display("FAIL bringup_run: got state %0d link %b err %0d required 5 / 1 / 0", state, link_up, err_cnt);
      end
   endtask

   task automatic test_lock_timeout();
      bit ok;
      int dwell, guard;
      do_reset();
      rx_plllckd = 1'b1;
      for (int r = 0; r < 3; r++) begin
         wait_state(S_WAIT_TX, 60, ok);
         dwell = 0; guard = 0;
         while (state === S_WAIT_TX && guard < 100) begin
            dwell++; tick(); guard++;
         end
         checks++;
         if (!ok || dwell != 20 || state !== S_TX_RST) begin
            errors++; $display("FAIL timeout_dwell_%0d: got %0d cycles then state %0d required 20 then 1", r, dwell, state);
         end
         checks++;
         if (err_cnt !== 8'(r + 1)) begin
            errors++; $display("FAIL timeout_err_%0d: got %0d required %0d", r, err_cnt, r + 1);
         end
      end
   endtask

   task automatic test_fifo_empty();
      bit ok;
      do_reset();
      bring_up();
      fifo_empty = 1'b1;
      tick();
      fifo_empty = 1'b0;
      wait_state(S_FLUSH, 10, ok);
      checks++;
      if (!ok || err_cnt !== 8'd1 || link_up !== 1'b0) begin
         errors++; $display("FAIL empty_flush: got state %0d err %0d link %b required 3 / 1 / 0", state, err_cnt, link_up);
      end
      wait_state(S_RUN, 30, ok);
      checks++;
      if (!ok || err_cnt !== 8'd1 || link_up !== 1'b1) begin
         errors++; $display("FAIL empty_relock: got state %0d err %0d link %b required 5 / 1 / 1", state, err_cnt, link_up);
      end
   endtask

   task automatic test_resel();
      bit ok;
      do_reset();
      bring_up();
      sel_sw = 2'b01;
      repeat (3) tick();
      sel_sw = 2'b00;
      repeat (12) tick();
      checks++;
      if (state !== S_RUN || clk_sel !== 2'b00) begin
         errors++; $display("FAIL resel_glitch: got state %0d clk_sel %b required 5 / 00", state, clk_sel);
      end
      sel_sw = 2'b01;
      wait_state(S_RESEL, 30, ok);
      checks++;
      if (!ok || clk_sel !== 2'b01 || tx_pll_reset !== 1'b1 || fifo_rst !== 1'b1 || err_cnt !== 8'd0) begin
         errors++; $display("FAIL resel_switch: got state %0d sel %b pll %b fifo %b err %0d required 6 / 01 / 1 / 1 / 0",
                            state, clk_sel, tx_pll_reset, fifo_rst, err_cnt);
      end
      tick();
      checks++;
      if (state !== S_TX_RST) begin
         errors++; $display("FAIL resel_exit: got %0d required %0d", state, S_TX_RST);
      end
      wait_state(S_RUN, 60, ok);
      checks++;
      if (!ok || clk_sel !== 2'b01 || err_cnt !== 8'd0) begin
         errors++; $display("FAIL resel_relock: got state %0d sel %b err %0d required 5 / 01 / 0", state, clk_sel, err_cnt);
      end
   endtask

   task automatic test_rx_drop();
      bit ok;
      do_reset();
      bring_up();
      rx_plllckd = 1'b0;
      fifo_full  = 1'b1;
      wait_state(S_WAIT_RX, 10, ok);
      checks++;
      if (!ok || err_cnt !== 8'd1) begin
         errors++; $display("FAIL rxdrop_wait_rx: got state %0d err %0d required 0 / 1", state, err_cnt);
      end
      repeat (5) tick();
      checks++;
      if (state !== S_WAIT_RX || err_cnt !== 8'd1 || tx_pll_reset !== 1'b1) begin
         errors++; $display("FAIL rxdrop_hold: got state %0d err %0d pll %b required 0 / 1 / 1", state, err_cnt, tx_pll_reset);
      end
      fifo_full = 1'b0;
   endtask

   task automatic test_reset_flush_and_saturate();
      bit ok;
      do_reset();
      rx_plllckd     = 1'b1;
      tx_bufpll_lock = 1'b1;
      wait_state(S_FLUSH, 40, ok);
      tick();
      checks++;
      if (!ok || state !== S_FLUSH) begin
         errors++; $display("FAIL midflush_reach: got %0d required %0d", state, S_FLUSH);
      end
      #3 rstin = 1'b1;
      #1;
      checks++;
      if (state !== S_WAIT_RX || {tx_pll_reset, fifo_rst, fifo_wr_en, fifo_rd_en, link_up} !== 5'b11000 ||
          clk_sel !== 2'b00 || err_cnt !== 8'd0) begin
         errors++; $display("FAIL midflush_async_reset: got state %0d outs %b sel %b err %0d required 0 / 11000 / 00 / 0",
                            state, {tx_pll_reset, fifo_rst, fifo_wr_en, fifo_rd_en, link_up}, clk_sel, err_cnt);
      end
      rx_plllckd     = 1'b0;
      tx_bufpll_lock = 1'b0;
      tick();
      rstin = 1'b0;
      repeat (5) tick();
      checks++;
      if (state !== S_WAIT_RX || fifo_rst !== 1'b1) begin
         errors++; $display("FAIL midflush_no_residue: got state %0d fifo_rst %b required 0 / 1", state, fifo_rst);
      end
      for (int p = 0; p < 300; p++) begin
         rx_psalgnerr = 1'b1;
         repeat (2) tick();
         rx_psalgnerr = 1'b0;
         repeat (2) tick();
         if (p == 99) begin
            checks++;
            if (err_cnt !== 8'd100) begin
               errors++; $display("FAIL psal_count_100: got %0d required 100", err_cnt);
            end
         end
      end
      checks++;
      if (err_cnt !== 8'd255) begin
         errors++; $display("FAIL psal_saturate: got %0d required 255", err_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_bring_up();
      test_lock_timeout();
      test_fifo_empty();
      test_resel();
      test_rx_drop();
      test_reset_flush_and_saturate();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
